sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 2: extra SRAM access cycles beyond one (range 0..7).
REQ-002 Parameter IO_ADDR, default 20'h0FFFF: memory-mapped I/O word address, used only when SRAM_ARBITER_IO_MAP_EN is defined.
REQ-003 Port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port Reset  in  1  synchronous, active-high reset.
REQ-005 Ports cpu_req/ldr_req  in  1 each  access request from CPU / loader, held until ready.
REQ-006 Ports cpu_we/ldr_we  in  1 each  1=write, 0=read.
REQ-007 Ports cpu_addr/ldr_addr  in  20 each  word address.
REQ-008 Ports cpu_wdata/ldr_wdata  in  16 each  write data.
REQ-009 Ports cpu_rdata/ldr_rdata  out  16 each  registered read data.
REQ-010 Ports cpu_ready/ldr_ready  out  1 each  one-cycle completion pulse.
REQ-011 Port S  in  16  switch value, returned on I/O reads.
REQ-012 Port hex_out  out  16  I/O write register, drives hex displays.
REQ-013 Ports CE, UB, LB, OE, WE  out  1 each  active-low SRAM controls.
REQ-014 Port ADDR  out  20  SRAM address; Data  inout  16  SRAM data bus.

Function
REQ-015 FSM states IDLE, ACCESS, DONE shall be used; IDLE->ACCESS on any request; ACCESS->DONE after WAIT_STATES+1 cycles; DONE->IDLE unconditionally.
REQ-016 In IDLE with both requests high, grant shall alternate round-robin, starting with CPU after reset; with one request, that requester is granted.
REQ-017 Granted port's addr, we and wdata shall be latched on the IDLE->ACCESS edge; later changes to inputs shall not affect the access.
REQ-018 During ACCESS: CE=0, UB=0, LB=0, ADDR=latched address; read: OE=0, WE=1, Data high-Z; write: OE=1, WE=0, Data driven with latched wdata.
REQ-019 Outside ACCESS: CE=OE=WE=UB=LB=1, ADDR=0, Data high-Z.
REQ-020 Read data shall be sampled from Data on the final ACCESS cycle into the granted port's rdata; the other port's rdata shall be unchanged.
REQ-021 Granted port's ready shall be 1 exactly during DONE; latency from request seen in IDLE to ready = WAIT_STATES+3 cycles.
REQ-022 A requester that drops req mid-access shall still receive its access completed and ready pulse.
REQ-023 Requests held high after ready shall start a new arbitration in the following IDLE cycle (minimum 1 idle cycle between accesses).

Reset
REQ-024 On Reset=1: state=IDLE, round-robin pointer=CPU, both ready=0, both rdata=0, hex_out=0, SRAM controls inactive, Data high-Z.
REQ-025 Reset asserted in ACCESS or DONE shall abort the access; no ready pulse shall be issued for it.

Configuration
REQ-026 Macro SRAM_ARBITER_IO_MAP_EN defined: an access with latched address == IO_ADDR shall bypass SRAM (controls stay inactive), read returning S, write loading hex_out, same FSM timing.
REQ-027 Macro undefined: IO_ADDR shall be an ordinary SRAM address, S shall be ignored, hex_out shall remain 0.

Structure
REQ-028 Package sram_arbiter_pkg shall hold the state enum, the grant-id typedef (GNT_CPU, GNT_LDR) and the default IO_ADDR constant.
REQ-029 The round-robin picker shall be a sub-module sram_arb_rr (two requests, last-grant pointer, one-hot grant).

Verification
REQ-030 Reset, then cpu read of 20'h00010 with bench driving Data=16'hBEEF, WAIT_STATES=2 -> OE low 3 cycles, cpu_ready pulse 5 cycles after req, cpu_rdata=16'hBEEF.
REQ-031 ldr write 16'h1234 to 20'h00020 -> WE low 3 cycles, Data=16'h1234 only during those cycles, ldr_ready one pulse.
REQ-032 cpu_req and ldr_req raised same cycle, held for 4 accesses -> grant order CPU, LDR, CPU, LDR.
REQ-033 Reset asserted second ACCESS cycle of a write -> next cycle WE=1, CE=1, Data high-Z, no ready pulse.
REQ-034 With SRAM_ARBITER_IO_MAP_EN, S=16'h0003, cpu read of 20'h0FFFF -> cpu_rdata=16'h0003, CE stays 1; cpu write 16'h00AB there -> hex_out=16'h00AB.
REQ-035 Without the macro, same write -> CE low, WE low, hex_out remains 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, grant ids, default I/O address.
// No logic here; imported by sram_arbiter and sram_arb_rr.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } gnt_e;

    localparam logic [19:0] IO_ADDR_DEFAULT = 20'h0FFFF;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: one-hot grant (bit0 CPU, bit1 LDR), combinational from requests.
// Pointer holds the last winner and only moves when i_take accepts a grant.
import sram_arbiter_pkg::*;

module sram_arb_rr (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    gnt_e r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = (r_last == GNT_CPU) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

    // Reset to "LDR was last" so the CPU wins the first contested cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= GNT_LDR;
        end else if (i_take && (i_req != 2'b00)) begin
            r_last <= o_gnt[1] ? GNT_LDR : GNT_CPU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU and loader onto one async SRAM; IDLE -> ACCESS (WAIT_STATES+1) -> DONE, ready during DONE.
// Requests are held until ready. SRAM_ARBITER_IO_MAP_EN maps IO_ADDR to the switch/hex registers.
import sram_arbiter_pkg::*;

module sram_arbiter #(
    parameter int          WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [19:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic [15:0] ldr_rdata,
    output logic        ldr_ready,
    input  logic [15:0] S,
    output logic [15:0] hex_out,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    localparam logic [2:0] LP_WS = 3'(WAIT_STATES);

    state_e      r_state;
    logic [2:0]  r_cnt;
    gnt_e        r_gnt;
    logic        r_we;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_ldr_rdata;

    logic [1:0]  w_gnt;
    logic        w_take;
    logic        w_io_hit;
    logic        w_sram;
    logic        w_last;
    logic [15:0] w_rd_src;

    assign w_take = (r_state == ST_IDLE);
    assign w_last = (r_cnt == LP_WS);

    sram_arb_rr u_rr (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_req   ({ldr_req, cpu_req}),
        .i_take  (w_take),
        .o_gnt   (w_gnt)
    );

`ifdef SRAM_ARBITER_IO_MAP_EN
    logic [15:0] r_hex;

    assign w_io_hit = (r_addr == IO_ADDR);
    assign w_rd_src = w_io_hit ? S : Data;
    assign hex_out  = r_hex;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hex <= '0;
        end else if (r_state == ST_ACCESS && w_last && r_we && w_io_hit) begin
            r_hex <= r_wdata;
        end
    end
`else
    logic w_unused;

    assign w_io_hit = 1'b0;
    assign w_rd_src = Data;
    assign hex_out  = '0;
    assign w_unused = ^{S, IO_ADDR};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gnt       <= GNT_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= '0;
                        r_gnt   <= w_gnt[1] ? GNT_LDR : GNT_CPU;
                        r_we    <= w_gnt[1] ? ldr_we    : cpu_we;
                        r_addr  <= w_gnt[1] ? ldr_addr  : cpu_addr;
                        r_wdata <= w_gnt[1] ? ldr_wdata : cpu_wdata;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        if (!r_we) begin
                            if (r_gnt == GNT_LDR) r_ldr_rdata <= w_rd_src;
                            else                  r_cpu_rdata <= w_rd_src;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An I/O-mapped access runs the same FSM but leaves the SRAM pins idle.
    assign w_sram = (r_state == ST_ACCESS) && !w_io_hit;

    assign CE   = ~w_sram;
    assign UB   = ~w_sram;
    assign LB   = ~w_sram;
    assign OE   = ~(w_sram && !r_we);
    assign WE   = ~(w_sram && r_we);
    assign ADDR = w_sram ? r_addr : 20'h0;
    assign Data = (w_sram && r_we) ? r_wdata : 16'hzzzz;

    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign cpu_ready = (r_state == ST_DONE) && (r_gnt == GNT_CPU) && !Reset;
    assign ldr_ready = (r_state == ST_DONE) && (r_gnt == GNT_LDR) && !Reset;

endmodule
